// File: rtl/ps2_matrix_kbd_pkg.sv
// Shared scancodes, decoder state and map-ROM entry layout for the PS/2 matrix keyboard.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_OVR_LO = 8'h00;
  localparam logic [7:0] SC_OVR_HI = 8'hFF;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_F11    = 8'h78;

  // Pause is E1 followed by seven more bytes that are swallowed
  localparam int unsigned SKIP_W     = 3;
  localparam logic [2:0]  PAUSE_SKIP = 3'd7;

  localparam int unsigned MAP_FW = 8;
  localparam int unsigned ADDR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_LOOKUP,
    ST_APPLY
  } dec_state_e;

  // Map-ROM entry widened to fixed field widths so range checks are size independent
  typedef struct packed {
    logic              valid;
    logic              special;
    logic [MAP_FW-1:0] row;
    logic [MAP_FW-1:0] col;
  } map_ent_t;

  function automatic logic is_flush_code(input logic [7:0] code);
    return (code == SC_BAT) || (code == SC_OVR_LO) || (code == SC_OVR_HI);
  endfunction

endpackage

// File: rtl/ps2_matrix_kbd_if.sv
// Scancode map ROM bus: keyboard drives {ext, scancode}, ROM returns an entry one cycle later.
interface ps2_map_if #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 12
);
  localparam int unsigned MW = 2 + $clog2(ROWS) + $clog2(COLS);

  logic [8:0]    map_addr;
  logic [MW-1:0] map_data;

  modport master (output map_addr, input  map_data);
  modport slave  (input  map_addr, output map_data);
endinterface

// File: rtl/ps2_matrix_kbd_rx.sv
// PS/2 byte receiver: synchronisers, clock glitch filter, frame shifter, parity/stop checks and timeout.
module ps2_rx #(
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_lvl;
  logic [FW-1:0] filt_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;

  logic flip;
  logic fall;
  logic timeout;
  logic frame_ok;

  // Filtered level flips on the FILT-th consecutive sample that disagrees with it
  assign flip    = (clk_sync[1] != filt_lvl) && (filt_cnt == FW'(FILT - 1));
  assign fall    = flip & filt_lvl;
  assign timeout = (bit_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT));

  // shreg holds start in [0], data in [8:1], parity in [9]; stop is the live sample
  assign frame_ok = ~shreg[0] & (^shreg[9:1]) & dat_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      filt_lvl   <= 1'b1;
      filt_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      code       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_dat};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (clk_sync[1] == filt_lvl) begin
        filt_cnt <= '0;
      end else if (flip) begin
        filt_lvl <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end

      // Idle-time counter saturates at TIMEOUT so it never wraps during long idles
      if (flip) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT)) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (timeout) begin
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            code       <= shreg[8:1];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shreg   <= {dat_sync[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard to host key-matrix emulator: prefix decoding, map-ROM lookup, matrix and modifier state.
module ps2_matrix_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 12,
  parameter int unsigned NMOD    = 4,
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_clk,
  input  logic             ps2_dat,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  input  logic [COLS-1:0]  col_in,
  output logic [ROWS-1:0]  row_out,
  ps2_map_if.master        map,
  output logic [NMOD-1:0]  mods,
  output logic             reset_key,
  output logic             frame_err
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned MW = 2 + RW + CW;
  localparam int unsigned MI = (NMOD > 1) ? $clog2(NMOD) : 1;

  logic [7:0] code;
  logic       byte_valid;

  ps2_rx #(
    .FILT    (FILT),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .code       (code),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  dec_state_e                 state_q, state_d;
  logic                       ext_q, ext_d;
  logic                       brk_q, brk_d;
  logic                       ctrl_q, ctrl_d;
  logic                       rkey_d;
  logic [SKIP_W-1:0]          skip_q, skip_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [ROWS-1:0][COLS-1:0]  matrix_q, matrix_d;
  logic [NMOD-1:0]            mods_d;
  map_ent_t                   ent;

  assign map.map_addr = addr_q;

  // Unpack the ROM word {valid, special, row, col} into fixed-width fields
  always_comb begin
    ent         = '0;
    ent.valid   = map.map_data[MW-1];
    ent.special = map.map_data[MW-2];
    ent.row     = MAP_FW'(map.map_data[RW+CW-1:CW]);
    ent.col     = MAP_FW'(map.map_data[CW-1:0]);
  end

  // Decoder next-state and next-value logic
  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    ctrl_d   = ctrl_q;
    rkey_d   = reset_key;
    skip_d   = skip_q;
    addr_d   = addr_q;
    matrix_d = matrix_q;
    mods_d   = mods;

    unique case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          if (code == SC_EXT) begin
            ext_d = 1'b1;
          end else if (code == SC_BRK) begin
            brk_d = 1'b1;
          end else if (code == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end else if (is_flush_code(code)) begin
            matrix_d = '0;
            mods_d   = '0;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
            ctrl_d   = 1'b0;
            rkey_d   = 1'b0;
          end else begin
            if (code == SC_CTRL) ctrl_d = ~brk_q;
            if (code == SC_F11)  rkey_d = ctrl_q & ~brk_q;
            addr_d  = {ext_q, code};
            state_d = ST_LOOKUP;
          end
        end
      end

      ST_SKIP: begin
        if (byte_valid) begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) state_d = ST_IDLE;
        end
      end

      ST_LOOKUP: state_d = ST_APPLY;

      ST_APPLY: begin
        // Out-of-range entries are silently dropped
        if (ent.valid) begin
          if (ent.special) begin
            if (ent.col < MAP_FW'(NMOD)) mods_d[ent.col[MI-1:0]] = ~brk_q;
          end else if ((ent.row < MAP_FW'(ROWS)) && (ent.col < MAP_FW'(COLS))) begin
            matrix_d[ent.row[RW-1:0]][ent.col[CW-1:0]] = ~brk_q;
          end
        end
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      ctrl_q    <= 1'b0;
      reset_key <= 1'b0;
      skip_q    <= '0;
      addr_q    <= '0;
      matrix_q  <= '0;
      mods      <= '0;
    end else begin
      state_q   <= state_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      ctrl_q    <= ctrl_d;
      reset_key <= rkey_d;
      skip_q    <= skip_d;
      addr_q    <= addr_d;
      matrix_q  <= matrix_d;
      mods      <= mods_d;
    end
  end

  // Bidirectional scan: a pressed key pulls its column low for a selected row and vice versa
  always_comb begin
    col_out = '1;
    row_out = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (matrix_q[r][c]) begin
          if (!row_in[r]) col_out[c] = 1'b0;
          if (!col_in[c]) row_out[r] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Randomised bench for ps2_matrix_kbd against a byte-level keyboard model and a registered map ROM.
module tb_ps2_matrix_kbd;
  import ps2_kbd_pkg::*;

  localparam int unsigned ROWS    = 6;
  localparam int unsigned COLS    = 12;
  localparam int unsigned NMOD    = 4;
  localparam int unsigned FILT    = 4;
  localparam int unsigned TIMEOUT = 400;
  localparam int unsigned HALF    = 12;
  localparam int unsigned GAP     = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            ps2_clk;
  logic            ps2_dat;
  logic [ROWS-1:0] row_in;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_in;
  logic [COLS-1:0] col_out;
  logic [NMOD-1:0] mods;
  logic            reset_key;
  logic            frame_err;

  ps2_map_if #(.ROWS(ROWS), .COLS(COLS)) map_bus ();

  ps2_matrix_kbd #(
    .ROWS(ROWS), .COLS(COLS), .NMOD(NMOD), .FILT(FILT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .row_in    (row_in),
    .col_out   (col_out),
    .col_in    (col_in),
    .row_out   (row_out),
    .map       (map_bus),
    .mods      (mods),
    .reset_key (reset_key),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Registered map ROM: {valid, special, row[2:0], col[3:0]}
  logic [8:0] rom [512];
  always @(posedge clk) map_bus.map_data <= rom[map_bus.map_addr];

  int err_seen = 0;
  always @(posedge clk) if (frame_err) err_seen <= err_seen + 1;

  // Reference model state
  bit              m_mat [ROWS][COLS];
  logic [NMOD-1:0] m_mods;
  bit              m_ctrl, m_rkey, m_ext, m_brk;
  int              m_skip;
  logic [8:0]      m_addr;
  int              exp_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ent(input bit v, input bit s, input int r, input int c);
    return {v, s, 3'(r), 4'(c)};
  endfunction

  task automatic model_reset();
    foreach (m_mat[r, c]) m_mat[r][c] = 1'b0;
    m_mods = '0;
    m_ctrl = 0; m_rkey = 0; m_ext = 0; m_brk = 0;
    m_skip = 0;
    m_addr = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] e;
    int r, c;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == SC_EXT) begin
      m_ext = 1;
    end else if (b == SC_BRK) begin
      m_brk = 1;
    end else if (b == SC_PAUSE) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == SC_BAT || b == SC_OVR_LO || b == SC_OVR_HI) begin
      foreach (m_mat[i, j]) m_mat[i][j] = 1'b0;
      m_mods = '0; m_ctrl = 0; m_rkey = 0; m_ext = 0; m_brk = 0;
    end else begin
      if (b == SC_CTRL) m_ctrl = !m_brk;
      if (b == SC_F11)  m_rkey = m_ctrl && !m_brk;
      m_addr = {m_ext, b};
      e = rom[m_addr];
      r = int'(e[6:4]);
      c = int'(e[3:0]);
      if (e[8]) begin
        if (e[7]) begin
          if (c < int'(NMOD)) m_mods[c] = !m_brk;
        end else if (r < int'(ROWS) && c < int'(COLS)) begin
          m_mat[r][c] = !m_brk;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  function automatic logic [COLS-1:0] exp_col(input logic [ROWS-1:0] rin);
    logic [COLS-1:0] v = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (m_mat[r][c] && !rin[r]) v[c] = 1'b0;
    return v;
  endfunction

  function automatic logic [ROWS-1:0] exp_row(input logic [COLS-1:0] cin);
    logic [ROWS-1:0] v = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_mat[r][c] && !cin[c]) v[r] = 1'b0;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(f, 11);
    cyc(GAP);
    if (bad_par) exp_err++;
    else         model_byte(b);
  endtask

  task automatic send_partial(input int n);
    send_bits(11'h7FE, n);
    cyc(TIMEOUT + 10);
    cyc(GAP);
    exp_err++;
  endtask

  task automatic check_model(input string tag);
    logic [ROWS-1:0] rin;
    logic [COLS-1:0] cin;
    chk({tag, ":mods"}, 32'(mods), 32'(m_mods));
    chk({tag, ":reset_key"}, 32'(reset_key), 32'(m_rkey));
    chk({tag, ":map_addr"}, 32'(map_bus.map_addr), 32'(m_addr));
    chk({tag, ":frame_err_count"}, 32'(err_seen), 32'(exp_err));
    for (int k = 0; k < 2; k++) begin
      rin = (k == 0) ? '0 : ROWS'($urandom);
      cin = (k == 0) ? '0 : COLS'($urandom);
      row_in = rin;
      col_in = cin;
      #1;
      chk({tag, ":col_out"}, 32'(col_out), 32'(exp_col(rin)));
      chk({tag, ":row_out"}, 32'(row_out), 32'(exp_row(cin)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r, e0;
    for (int i = 0; i < 512; i++) begin
      rom[i] = 9'($urandom);
      if ($urandom_range(0, 3) != 0) rom[i][8] = 1'b1;
    end
    rom[9'h01C] = ent(1, 0, 2, 5);
    rom[9'h014] = ent(1, 0, 0, 1);
    rom[9'h077] = ent(1, 0, 1, 2);
    rom[9'h015] = ent(1, 0, 1, 1);
    rom[9'h01D] = ent(1, 0, 4, 7);
    rom[9'h024] = ent(1, 0, 5, 11);
    rom[9'h012] = ent(1, 1, 0, 2);
    rom[9'h02D] = ent(1, 0, 6, 0);
    rom[9'h02C] = ent(1, 1, 0, 5);
    rom[9'h016] = ent(1, 0, 0, 0);
    rom[9'h01E] = ent(1, 0, 3, 11);

    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; row_in = '1; col_in = '1;
    exp_err = 0;
    model_reset();
    cyc(3);
    chk("reset:frame_err", 32'(frame_err), 32'd0);
    check_model("reset");
    reset = 1'b0;
    cyc(4);

    // Single key press and release
    send(8'h1C, 0);
    row_in = ~(6'b1 << 2); #1;
    chk("press_1c:col_out", 32'(col_out), 32'hFDF);
    check_model("press_1c");
    send(SC_BRK, 0); send(8'h1C, 0);
    row_in = '0; #1;
    chk("release_1c:col_out", 32'(col_out), 32'hFFF);
    check_model("release_1c");

    // Extended and plain lookup address
    send(SC_EXT, 0); send(8'h75, 0);
    chk("ext_addr", 32'(map_bus.map_addr), 32'h175);
    send(8'h75, 0);
    chk("plain_addr", 32'(map_bus.map_addr), 32'h075);
    check_model("addr");

    // Parity error, then timeout of a partial frame, then a good frame
    e0 = err_seen;
    send(8'h1C, 1);
    chk("bad_parity:pulses", 32'(err_seen - e0), 32'd1);
    check_model("bad_parity");
    e0 = err_seen;
    send_partial(3);
    chk("timeout:pulses", 32'(err_seen - e0), 32'd1);
    send(8'h1C, 0);
    row_in = ~(6'b1 << 2); #1;
    chk("after_timeout:col5", 32'(col_out[5]), 32'd0);
    check_model("after_timeout");

    // Ctrl+F11 reset key
    send(SC_CTRL, 0); send(SC_F11, 0);
    chk("ctrl_f11:reset_key", 32'(reset_key), 32'd1);
    send(SC_BRK, 0); send(SC_F11, 0);
    chk("f11_up:reset_key", 32'(reset_key), 32'd0);
    send(SC_BRK, 0); send(SC_CTRL, 0); send(SC_F11, 0);
    chk("f11_alone:reset_key", 32'(reset_key), 32'd0);
    send(SC_BRK, 0); send(SC_F11, 0);
    check_model("reset_key");

    // Several keys and a modifier, with out-of-range entries, then BAT flush
    send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h12, 0);
    send(8'h2D, 0); send(8'h2C, 0);
    chk("shift:mods2", 32'(mods[2]), 32'd1);
    check_model("three_keys");
    send(SC_BAT, 0);
    row_in = '0; col_in = '0; #1;
    chk("bat:col_out", 32'(col_out), 32'hFFF);
    chk("bat:row_out", 32'(row_out), 32'h3F);
    chk("bat:mods", 32'(mods), 32'd0);
    check_model("bat");

    // Pause sequence is ignored
    send(SC_PAUSE, 0); send(8'h14, 0); send(8'h77, 0); send(SC_PAUSE, 0);
    send(SC_BRK, 0); send(8'h14, 0); send(SC_BRK, 0); send(8'h77, 0);
    row_in = '0; col_in = '0; #1;
    chk("pause:col_out", 32'(col_out), 32'hFFF);
    chk("pause:row_out", 32'(row_out), 32'h3F);
    send(8'h1C, 0);
    row_in = ~(6'b1 << 2); #1;
    chk("after_pause:col_out", 32'(col_out), 32'hFDF);
    check_model("pause");

    // Bidirectional scan
    send(8'h16, 0); send(8'h1E, 0);
    col_in = ~(12'b1 << 11); #1;
    chk("scan:row_out", 32'(row_out), 32'h37);
    row_in = ~6'b1; #1;
    chk("scan:col_out", 32'(col_out), 32'hFFE);
    check_model("scan");

    // Reset in the middle of a frame
    send_bits(11'h7FE, 5);
    reset = 1'b1;
    cyc(1);
    row_in = '0; col_in = '0; #1;
    chk("mid_reset:col_out", 32'(col_out), 32'hFFF);
    chk("mid_reset:row_out", 32'(row_out), 32'h3F);
    chk("mid_reset:mods", 32'(mods), 32'd0);
    chk("mid_reset:reset_key", 32'(reset_key), 32'd0);
    chk("mid_reset:map_addr", 32'(map_bus.map_addr), 32'd0);
    chk("mid_reset:frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    model_reset();
    cyc(GAP);
    check_model("post_reset");

    // Random traffic
    for (int k = 0; k < 100; k++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      send(SC_EXT, 0);
      else if (r < 22) send(SC_BRK, 0);
      else if (r < 25) send(SC_PAUSE, 0);
      else if (r < 27) send(SC_BAT, 0);
      else if (r < 32) send(8'($urandom), 1);
      else if (r < 34) send_partial($urandom_range(1, 9));
      else             send(8'($urandom_range(1, 127)), 0);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
